// File: rtl/cond_flag_unit_pkg.sv
// cond_flag_unit_pkg: flag bit indices, condition codes and FSM states shared with ALU and decode.
package cond_flag_unit_pkg;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;
    typedef enum logic {NORM, EXC} state_t;
endpackage

// File: rtl/cond_flag_unit_if.sv
// cond_flag_unit_if: flag write, condition request, exception pulses and status outputs.
interface cond_flag_unit_if #(parameter int CNT_W = 16);
    logic [3:0] nzcv_in;
    logic flag_we;
    logic [3:0] cond;
    logic cond_valid;
    logic exc_entry;
    logic exc_return;
    logic [3:0] flags;
    logic c_out;
    logic v_out;
    logic pass_valid;
    logic pass;
    logic in_exc;
    logic exc_err;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    modport master(
        output nzcv_in, flag_we, cond, cond_valid, exc_entry, exc_return,
        input flags, c_out, v_out, pass_valid, pass, in_exc, exc_err, pass_cnt, fail_cnt
    );
    modport slave(
        input nzcv_in, flag_we, cond, cond_valid, exc_entry, exc_return,
        output flags, c_out, v_out, pass_valid, pass, in_exc, exc_err, pass_cnt, fail_cnt
    );
endinterface

// File: rtl/cond_flag_unit_cond_check.sv
// cond_check: combinational ARM-style condition evaluation against an NZCV value.
module cond_check
    import cond_flag_unit_pkg::*;
(
    input logic [3:0] cond,
    input logic [3:0] nzcv,
    output logic pass
);
    logic n, z, c, v;
    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = n == v;
            COND_LT: pass = n != v;
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: NZCV flags register, registered condition evaluation,
// single-level exception save slot and saturating pass/fail counters.
module cond_flag_unit
    import cond_flag_unit_pkg::*;
#(
    parameter bit FWD = 1'b1,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    cond_flag_unit_if.slave bus
);
    state_t state, state_nx;
    logic [3:0] flags_q, saved, flags_nx, saved_nx, eval_flags;
    logic entry_ok, ret_ok, err_set, eval_pass;
    logic pass_q, pass_valid_q, exc_err_q;
    logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;

    cond_check u_check (.cond(bus.cond), .nzcv(eval_flags), .pass(eval_pass));

    always_comb begin
        entry_ok = bus.exc_entry && !bus.exc_return && state == NORM;
        ret_ok = bus.exc_return && !bus.exc_entry && state == EXC;
        err_set = (bus.exc_entry || bus.exc_return) && !entry_ok && !ret_ok;
        state_nx = ret_ok ? NORM : entry_ok ? EXC : state;
        flags_nx = ret_ok ? saved : bus.flag_we ? bus.nzcv_in : flags_q;
        saved_nx = entry_ok ? flags_q : saved;
        // forwarding sees exactly what the flags register is about to take
        eval_flags = FWD ? flags_nx : flags_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= NORM;
        else state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'b0000;
            saved <= 4'b0000;
            exc_err_q <= 1'b0;
            pass_valid_q <= 1'b0;
            pass_q <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            flags_q <= flags_nx;
            saved <= saved_nx;
            exc_err_q <= exc_err_q || err_set;
            pass_valid_q <= bus.cond_valid;
            pass_q <= bus.cond_valid && eval_pass;
            if (bus.cond_valid && eval_pass && pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
            if (bus.cond_valid && !eval_pass && fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
        end
    end

    assign bus.flags = flags_q;
    assign bus.c_out = flags_q[FLAG_C];
    assign bus.v_out = flags_q[FLAG_V];
    assign bus.pass_valid = pass_valid_q;
    assign bus.pass = pass_q;
    assign bus.in_exc = state == EXC;
    assign bus.exc_err = exc_err_q;
    assign bus.pass_cnt = pass_cnt_q;
    assign bus.fail_cnt = fail_cnt_q;
endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: drives a forwarding/16-bit-counter unit and a registered-only/2-bit-counter unit
// with identical stimulus and compares both against a table-driven reference model.
module tb_cond_flag_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] nzcv_in = '0, cond = '0;
    logic flag_we = 1'b0, cond_valid = 1'b0, exc_entry = 1'b0, exc_return = 1'b0;
    int checks = 0, errs = 0;

    bit [3:0] m_flags[2], m_saved[2];
    bit m_exc[2], m_err[2], m_pv[2], m_p[2];
    int m_pc[2], m_fc[2];

    always #5 clk = ~clk;

    cond_flag_unit_if #(.CNT_W(16)) if1 ();
    cond_flag_unit_if #(.CNT_W(2)) if0 ();

    assign if1.nzcv_in = nzcv_in;
    assign if1.flag_we = flag_we;
    assign if1.cond = cond;
    assign if1.cond_valid = cond_valid;
    assign if1.exc_entry = exc_entry;
    assign if1.exc_return = exc_return;
    assign if0.nzcv_in = nzcv_in;
    assign if0.flag_we = flag_we;
    assign if0.cond = cond;
    assign if0.cond_valid = cond_valid;
    assign if0.exc_entry = exc_entry;
    assign if0.exc_return = exc_return;

    cond_flag_unit #(.FWD(1'b1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    cond_flag_unit #(.FWD(1'b0), .CNT_W(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));

    // Conditions come in complementary pairs; odd codes invert the even predicate (AL/NV included).
    function automatic bit ref_cond(int c, bit [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0], b;
        case (c / 2)
            0: b = z;
            1: b = cy;
            2: b = n;
            3: b = v;
            4: b = cy && !z;
            5: b = n == v;
            6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return (c % 2 == 1) ? !b : b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_flags[k] = 0; m_saved[k] = 0; m_exc[k] = 0; m_err[k] = 0;
            m_pv[k] = 0; m_p[k] = 0; m_pc[k] = 0; m_fc[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit ent = exc_entry && !exc_return && !m_exc[k];
            bit ret = exc_return && !exc_entry && m_exc[k];
            bit [3:0] src = m_flags[k];
            int maxc = (k == 0) ? 65535 : 3;
            if ((exc_entry || exc_return) && !ent && !ret) m_err[k] = 1;
            if (k == 0 && ret) src = m_saved[k];
            else if (k == 0 && flag_we) src = nzcv_in;
            m_pv[k] = cond_valid;
            m_p[k] = cond_valid && ref_cond(int'(cond), src);
            if (cond_valid && m_p[k] && m_pc[k] < maxc) m_pc[k]++;
            if (cond_valid && !m_p[k] && m_fc[k] < maxc) m_fc[k]++;
            if (ent) begin m_saved[k] = m_flags[k]; m_exc[k] = 1; end
            if (ret) begin m_flags[k] = m_saved[k]; m_exc[k] = 0; end
            else if (flag_we) m_flags[k] = nzcv_in;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("f1.flags", 32'(if1.flags), 32'(m_flags[0]));
        chk("f1.c_out", 32'(if1.c_out), 32'(m_flags[0][1]));
        chk("f1.v_out", 32'(if1.v_out), 32'(m_flags[0][0]));
        chk("f1.pass_valid", 32'(if1.pass_valid), 32'(m_pv[0]));
        chk("f1.pass", 32'(if1.pass), 32'(m_p[0]));
        chk("f1.in_exc", 32'(if1.in_exc), 32'(m_exc[0]));
        chk("f1.exc_err", 32'(if1.exc_err), 32'(m_err[0]));
        chk("f1.pass_cnt", 32'(if1.pass_cnt), 32'(m_pc[0]));
        chk("f1.fail_cnt", 32'(if1.fail_cnt), 32'(m_fc[0]));
        chk("f0.flags", 32'(if0.flags), 32'(m_flags[1]));
        chk("f0.c_out", 32'(if0.c_out), 32'(m_flags[1][1]));
        chk("f0.v_out", 32'(if0.v_out), 32'(m_flags[1][0]));
        chk("f0.pass_valid", 32'(if0.pass_valid), 32'(m_pv[1]));
        chk("f0.pass", 32'(if0.pass), 32'(m_p[1]));
        chk("f0.in_exc", 32'(if0.in_exc), 32'(m_exc[1]));
        chk("f0.exc_err", 32'(if0.exc_err), 32'(m_err[1]));
        chk("f0.pass_cnt", 32'(if0.pass_cnt), 32'(m_pc[1]));
        chk("f0.fail_cnt", 32'(if0.fail_cnt), 32'(m_fc[1]));
    endtask

    task automatic drive(bit we, bit [3:0] nz, bit cv, bit [3:0] c, bit en, bit er);
        flag_we = we; nzcv_in = nz; cond_valid = cv; cond = c; exc_entry = en; exc_return = er;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Reset is raised between edges and checked before any edge can occur.
    task automatic async_reset();
        #2 rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        model_reset();
        check_all();
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #12 rst = 1'b0;
        check_all();
        drive(1, 4'b0100, 0, 0, 0, 0); tick();
        chk("dir.flags_0100", 32'(if1.flags), 32'h4);
        drive(0, 0, 1, 4'h0, 0, 0); tick();
        chk("dir.eq_valid", 32'(if1.pass_valid), 32'h1);
        chk("dir.eq_pass", 32'(if1.pass), 32'h1);
        drive(0, 0, 1, 4'h1, 0, 0); tick();
        chk("dir.ne_pass", 32'(if1.pass), 32'h0);
        drive(0, 0, 0, 0, 0, 0); tick();
        chk("dir.idle_valid", 32'(if1.pass_valid), 32'h0);
        drive(1, 4'b0000, 0, 0, 0, 0); tick();
        drive(1, 4'b1001, 1, 4'hA, 0, 0); tick();
        chk("fwd1.ge", 32'(if1.pass), 32'h1);
        chk("fwd0.ge", 32'(if0.pass), 32'h1);
        drive(1, 4'b0000, 0, 0, 0, 0); tick();
        drive(1, 4'b1001, 1, 4'hB, 0, 0); tick();
        chk("fwd1.lt", 32'(if1.pass), 32'h0);
        chk("fwd0.lt", 32'(if0.pass), 32'h0);
        drive(1, 4'b0110, 1, 4'h8, 0, 0); tick();
        chk("fwd1.hi_sees_new", 32'(if1.pass), 32'h0);

        async_reset();
        for (int f = 0; f < 16; f++) begin
            drive(1, 4'(f), 0, 0, 0, 0); tick();
            for (int c = 0; c < 16; c++) begin
                drive(0, 0, 1, 4'(c), 0, 0); tick();
            end
        end
        drive(0, 0, 0, 0, 0, 0); tick();
        chk("sweep.total", 32'(if1.pass_cnt) + 32'(if1.fail_cnt), 32'd256);

        async_reset();
        drive(1, 4'b0010, 0, 0, 0, 0); tick();
        drive(1, 4'b1000, 0, 0, 1, 0); tick();
        chk("exc.entry_flags", 32'(if1.flags), 32'h8);
        chk("exc.entry_in_exc", 32'(if1.in_exc), 32'h1);
        drive(0, 0, 0, 0, 0, 1); tick();
        chk("exc.ret_flags", 32'(if1.flags), 32'h2);
        chk("exc.ret_in_exc", 32'(if1.in_exc), 32'h0);
        chk("exc.no_err", 32'(if1.exc_err), 32'h0);
        drive(0, 0, 0, 0, 0, 1); tick();
        chk("exc.ret_in_norm_err", 32'(if1.exc_err), 32'h1);
        chk("exc.ret_in_norm_flags", 32'(if1.flags), 32'h2);
        drive(0, 0, 0, 0, 1, 0); tick();
        drive(1, 4'b0101, 0, 0, 1, 0); tick();
        drive(0, 0, 1, 4'h0, 0, 1); tick();
        chk("exc.saved_kept", 32'(if1.flags), 32'h2);
        chk("exc.fwd_saved_eq", 32'(if1.pass), 32'h0);
        chk("exc.err_sticky", 32'(if1.exc_err), 32'h1);
        drive(0, 0, 1, 4'hE, 1, 1); tick();
        async_reset();

        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 4'hE, 0, 0); tick();
        end
        chk("sat.cnt2_pass", 32'(if0.pass_cnt), 32'd3);
        chk("sat.cnt2_fail", 32'(if0.fail_cnt), 32'd0);
        chk("sat.cnt16_pass", 32'(if1.pass_cnt), 32'd5);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 2) == 0), 4'($urandom), 1'($urandom_range(0, 3) != 0),
                  4'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
            tick();
            if (i == 200) async_reset();
        end
        drive(0, 0, 0, 0, 0, 0); tick();
        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end
endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Consumer side of the ALU flag interface: holds the architectural NZCV flags register, latches new ALU flags on S-type writes, and feeds C and V back to the ALU.
- Evaluates the 4-bit ARM-style condition field of the next instruction against the flags, with one-cycle registered latency.
- Provides a single-level saved-flags slot for exception entry/return, plus saturating pass/fail statistics counters.

Parameters:
- FWD, 1, 1 = a flag write in the same cycle as a condition request is forwarded into that evaluation; 0 = evaluation uses the registered flags only.
- CNT_W, 16, width of each saturating statistics counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- nzcv_in  in  4  flags from ALU, bit3 N, bit2 Z, bit1 C, bit0 V
- flag_we  in  1  write nzcv_in into flags this cycle (instruction S bit AND instruction valid)
- cond  in  4  condition field to evaluate
- cond_valid  in  1  condition request this cycle
- exc_entry  in  1  pulse: save flags to saved slot
- exc_return  in  1  pulse: restore flags from saved slot
- flags  out  4  current flags register
- c_out  out  1  flags[1], to ALU C input
- v_out  out  1  flags[0], to ALU V input
- pass_valid  out  1  registered result valid
- pass  out  1  condition result, qualified by pass_valid
- in_exc  out  1  FSM is in state EXC
- exc_err  out  1  sticky illegal-sequence error
- pass_cnt  out  CNT_W  number of evaluations that passed
- fail_cnt  out  CNT_W  number of evaluations that failed

Behaviour:
- Reset: flags=0000, saved slot=0000, pass_valid=0, pass=0, FSM=NORM, in_exc=0, exc_err=0, both counters=0. Reset asserted mid-operation clears everything immediately; any evaluation in flight is lost.
- Flag update priority at each edge: exc_return (legal) > flag_we > hold.
- exc_entry together with flag_we: the saved slot takes the old flags and flags takes nzcv_in.
- Condition table:
  - 0 EQ = Z; 1 NE = !Z; 2 CS = C; 3 CC = !C
  - 4 MI = N; 5 PL = !N; 6 VS = V; 7 VC = !V
  - 8 HI = C&!Z; 9 LS = !C|Z
  - A GE = N==V; B LT = N!=V; C GT = !Z&(N==V); D LE = Z|(N!=V)
  - E AL = 1; F NV = 0
- Latency: cond_valid sampled at edge t gives pass_valid=1 and pass during cycle t+1. Without a request, pass_valid=0 and pass=0. Back-to-back requests produce back-to-back results. There is no backpressure.
- Evaluated flag source:
  - FWD=1 and flag_we the same cycle: nzcv_in.
  - FWD=1 and exc_return (legal) the same cycle: the saved slot, which takes priority over forwarding.
  - Otherwise: the registered flags.
  - FWD=0: always the registered flags.
- FSM, two states:
  - NORM: exc_entry saves flags and moves to EXC. exc_return is ignored and sets exc_err.
  - EXC: exc_return restores flags from the saved slot and moves to NORM. exc_entry is ignored (no nesting; saved slot unchanged) and sets exc_err.
  - exc_entry and exc_return in the same cycle: both ignored, exc_err set, state unchanged.
- exc_err clears only on reset.
- Counters: on each evaluation, pass_cnt or fail_cnt increments by 1, updated on the same edge as the pass result. Each counter saturates at 2^CNT_W-1 with no wrap.
- flags, c_out and v_out are purely registered and change only at clock edges.

Decomposition:
- Shared package: flag bit indices (N=3, Z=2, C=1, V=0) and condition code constants COND_EQ..COND_NV. The ALU uses the same flag indices.
- One natural combinational sub-module, cond_check (inputs: cond, nzcv; output: pass), reused by the decode stage.
- The FSM, registers and counters live in cond_flag_unit.

Test Plan:
- Reset, then flag_we with nzcv_in=0100 -> next cycle flags=0100. cond=0 with cond_valid -> pass_valid=1, pass=1 one cycle later. cond=1 -> pass=0.
- FWD=1: flags=0000, same cycle flag_we with nzcv_in=1001 and cond=A (GE) -> pass=1 (N==V via forwarding). With FWD=0 -> pass=1 from 0000 as well. cond=B (LT) -> pass=0 under FWD=1, pass=0 under FWD=0.
- Sweep all 16 cond values against all 16 flag values -> pass matches the condition table exactly, including F=0 and E=1; pass_cnt+fail_cnt=256.
- flags=0010, exc_entry with flag_we nzcv_in=1000 -> flags=1000, in_exc=1. exc_return -> flags=0010, in_exc=0.
- exc_return in NORM -> exc_err=1, flags unchanged. Second exc_entry in EXC -> saved slot unchanged, exc_err stays 1. rst mid-sequence -> all outputs return to reset values asynchronously.
- CNT_W=2: 5 passing evaluations -> pass_cnt=3 (saturated), fail_cnt=0.
